// File: rtl/qam_pkg.sv
// Shared defaults and state encoding for the QAM symbol sequencer.
package qam_pkg;

  localparam int unsigned SYM_W_DEF           = 4;
  localparam int unsigned IDX_W_DEF           = 4;
  localparam int unsigned SAMPLES_PER_SYM_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } qseq_state_e;

endpackage : qam_pkg

// File: rtl/qseq_hold_buf.sv
// Single-entry symbol holding register with a registered full flag.
// load and consume are mutually exclusive by construction (load needs empty,
// consume needs full), so no priority is required between them.
module qseq_hold_buf #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         consume,
  input  logic [W-1:0] din,
  output logic [W-1:0] data,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // Next-state for the stored symbol and occupancy flag.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (consume) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = din;
    end
  end

  // Storage registers; reset empties the buffer and discards its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule : qseq_hold_buf

// File: rtl/qam_symbol_sequencer.sv
// Symbol-rate controller: plays each buffered symbol as SAMPLES_PER_SYM
// table-select/sample-index addresses, back to back with no gap.
// Optional build macro QSEQ_UNDERRUN_CNT_EN adds a saturating underrun
// counter (underrun_cnt) with a synchronous clear input (cnt_clr).
module qam_symbol_sequencer
  import qam_pkg::*;
#(
  parameter int unsigned SYM_W           = SYM_W_DEF,
  parameter int unsigned IDX_W           = IDX_W_DEF,
  parameter int unsigned SAMPLES_PER_SYM = SAMPLES_PER_SYM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [SYM_W-1:0] tbl_sel,
  output logic [IDX_W-1:0] sample_idx,
  output logic             sample_valid,
  output logic             sym_start,
  output logic             underrun,
  output logic             busy
`ifdef QSEQ_UNDERRUN_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [15:0]      underrun_cnt
`endif
);

  // Explicit terminal index so non-power-of-two symbol lengths wrap correctly.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_SYM - 1);

  qseq_state_e      state_q, state_d;
  logic [SYM_W-1:0] tbl_sel_q, tbl_sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             underrun_q, underrun_d;

  logic             buf_full;
  logic [SYM_W-1:0] buf_data;
  logic             buf_load;
  logic             buf_consume;
  logic             at_last;

  assign sym_ready = ~buf_full;
  assign buf_load  = sym_valid & ~buf_full;
  assign at_last   = (idx_q == LAST_IDX);

  qseq_hold_buf #(
    .W (SYM_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .consume (buf_consume),
    .din     (sym_in),
    .data    (buf_data),
    .full    (buf_full)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tbl_sel_q  <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tbl_sel_q  <= tbl_sel_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state: start on a buffered symbol, stop when a symbol ends unfed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (buf_full && en) state_d = PLAY;
      PLAY: if (en && at_last && !buf_full) state_d = IDLE;
    endcase
  end

  // Output/address generation; a frozen or idle cycle holds the address.
  always_comb begin
    tbl_sel_d   = tbl_sel_q;
    idx_d       = idx_q;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    underrun_d  = 1'b0;
    buf_consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_full && en) begin
          tbl_sel_d   = buf_data;
          idx_d       = '0;
          valid_d     = 1'b1;
          start_d     = 1'b1;
          buf_consume = 1'b1;
        end
      end
      PLAY: begin
        if (en) begin
          if (!at_last) begin
            idx_d   = idx_q + IDX_W'(1);
            valid_d = 1'b1;
          end else if (buf_full) begin
            tbl_sel_d   = buf_data;
            idx_d       = '0;
            valid_d     = 1'b1;
            start_d     = 1'b1;
            buf_consume = 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign tbl_sel      = tbl_sel_q;
  assign sample_idx   = idx_q;
  assign sample_valid = valid_q;
  assign sym_start    = start_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q != IDLE);

`ifdef QSEQ_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of underrun pulses; clear wins over a coincident pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (underrun_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign underrun_cnt = cnt_q;
`endif

endmodule : qam_symbol_sequencer

// File: tb/tb_qam_symbol_sequencer.sv
// Directed bench for qam_symbol_sequencer: default 16-sample instance plus a
// 12-sample instance sharing clock, reset and enable.
module tb_qam_symbol_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic [3:0] tbl_sel;
  logic [3:0] sample_idx;
  logic       sample_valid, sym_start, underrun, busy;

  logic [3:0] sym_in12;
  logic       sym_valid12, sym_ready12;
  logic [3:0] tbl_sel12, sample_idx12;
  logic       sample_valid12, sym_start12, underrun12, busy12;

`ifdef QSEQ_UNDERRUN_CNT_EN
  logic        cnt_clr;
  logic [15:0] underrun_cnt, underrun_cnt12;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qam_symbol_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sym_in       (sym_in),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .tbl_sel      (tbl_sel),
    .sample_idx   (sample_idx),
    .sample_valid (sample_valid),
    .sym_start    (sym_start),
    .underrun     (underrun),
    .busy         (busy)
`ifdef QSEQ_UNDERRUN_CNT_EN
    ,
    .cnt_clr      (cnt_clr),
    .underrun_cnt (underrun_cnt)
`endif
  );

  qam_symbol_sequencer #(.SAMPLES_PER_SYM(12)) dut12 (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sym_in       (sym_in12),
    .sym_valid    (sym_valid12),
    .sym_ready    (sym_ready12),
    .tbl_sel      (tbl_sel12),
    .sample_idx   (sample_idx12),
    .sample_valid (sample_valid12),
    .sym_start    (sym_start12),
    .underrun     (underrun12),
    .busy         (busy12)
`ifdef QSEQ_UNDERRUN_CNT_EN
    ,
    .cnt_clr      (cnt_clr),
    .underrun_cnt (underrun_cnt12)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got, exp;
    rst = 1'b1;
    tick();
    tick();
    got = {tbl_sel, sample_idx, sample_valid, sym_start, underrun, busy, sym_ready, busy12};
    exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_symbol();
    logic [11:0] got, exp;
    sym_in = 4'd11;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    checks++;
    if ({sym_ready, sample_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_accept got=%b exp=000", {sym_ready, sample_valid, busy});
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      got = {tbl_sel, sample_idx, sample_valid, sym_start, underrun, busy};
      exp = {4'd11, 4'(i), 1'b1, (i == 0), 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_sample%0d got=%h exp=%h", i, got, exp);
      end
    end
    tick();
    got = {tbl_sel, sample_idx, sample_valid, sym_start, underrun, busy};
    exp = {4'd11, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL single_underrun got=%h exp=%h", got, exp);
    end
    tick();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL single_underrun_pulse got=%b exp=0", underrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    sym_in = 4'd3;
    sym_valid = 1'b1;
    tick();
    sym_in = 4'd12;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 1) sym_valid = 1'b0;
      got = {tbl_sel, sample_idx, sample_valid, sym_start, underrun, sym_ready};
      exp = {(k < 16) ? 4'd3 : 4'd12, 4'(k % 16), 1'b1, (k % 16 == 0), 1'b0,
             (k == 0 || k >= 16)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%h exp=%h", k, got, exp);
      end
    end
    tick();
    checks++;
    if ({underrun, sample_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_end got=%b exp=100", {underrun, sample_valid, busy});
    end
  endtask

  task automatic test_enable_freeze();
    logic [7:0] got, exp;
    int         nvalid;
    nvalid = 0;
    sym_in = 4'd6;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sample_valid === 1'b1 && sample_idx === 4'(i)) nvalid++;
    end
    en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      got = {sample_idx, sample_valid, sym_start, underrun, busy};
      exp = {4'd7, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL freeze_hold%0d got=%h exp=%h", j, got, exp);
      end
    end
    en = 1'b1;
    for (int i = 8; i < 16; i++) begin
      tick();
      if (sample_valid === 1'b1 && sample_idx === 4'(i) && sym_start === 1'b0) nvalid++;
    end
    checks++;
    if (nvalid !== 16) begin
      errors++;
      $display("FAIL freeze_valid_count got=%0d exp=16", nvalid);
    end
    en = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      got = {sample_idx, sample_valid, sym_start, underrun, busy};
      exp = {4'd15, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL freeze_last%0d got=%h exp=%h", j, got, exp);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({underrun, sample_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL freeze_end got=%b exp=100", {underrun, sample_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] got, exp;
    logic        seen;
    seen = 1'b0;
    sym_in = 4'd9;
    sym_valid = 1'b1;
    tick();
    sym_in = 4'd5;
    tick();
    tick();
    sym_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if ({tbl_sel, sample_idx, sym_ready} !== {4'd9, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL midrst_setup got=%h exp=%h", {tbl_sel, sample_idx, sym_ready}, {4'd9, 4'd9, 1'b0});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {tbl_sel, sample_idx, sample_valid, sym_start, underrun, busy, sym_ready};
    exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL midrst_state got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_valid !== 1'b0 || underrun !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_discard got=%b exp=0", seen);
    end
  endtask

  task automatic test_spw12();
    logic [9:0] got, exp;
    sym_in12 = 4'd2;
    sym_valid12 = 1'b1;
    tick();
    sym_valid12 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      got = {tbl_sel12, sample_idx12, sample_valid12, sym_start12};
      exp = {4'd2, 4'(i), 1'b1, (i == 0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL spw12_sample%0d got=%h exp=%h", i, got, exp);
      end
    end
    tick();
    got = {tbl_sel12, sample_idx12, sample_valid12, underrun12};
    exp = {4'd2, 4'd11, 1'b0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL spw12_end got=%h exp=%h", got, exp);
    end
  endtask

`ifdef QSEQ_UNDERRUN_CNT_EN
  task automatic play_one(input logic [3:0] s);
    sym_in = s;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
  endtask

  task automatic test_underrun_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clear got=%0d exp=0", underrun_cnt);
    end
    for (int n = 0; n < 3; n++) begin
      play_one(4'd1);
      tick();
    end
    checks++;
    if (underrun_cnt !== 16'd3) begin
      errors++;
      $display("FAIL cnt_three got=%0d exp=3", underrun_cnt);
    end
    play_one(4'd4);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick();
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clr_coincide got=%0d exp=0", underrun_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    en = 1'b1;
    sym_in = '0;
    sym_valid = 1'b0;
    sym_in12 = '0;
    sym_valid12 = 1'b0;
`ifdef QSEQ_UNDERRUN_CNT_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_single_symbol();
    test_back_to_back();
    test_enable_freeze();
    test_reset_mid();
    test_spw12();
`ifdef QSEQ_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_qam_symbol_sequencer

// File: doc/qam_symbol_sequencer.md
Name: qam_symbol_sequencer

Overview:
- Symbol-rate controller for the 16-sample waveform lookup tables (one 8-bit table per symbol/phase, 16 entries each).
- Accepts symbols over a valid/ready handshake and holds one symbol in a buffer.
- For each symbol, drives the table-select and sample-index addresses across exactly SAMPLES_PER_SYM clocks.
- Sits between the symbol mapper and the waveform table bank/output mux. Back-to-back symbols play with no gap.

Parameters:
- SYM_W, 4, symbol width (selects one of 2^SYM_W tables)
- IDX_W, 4, sample-index width
- SAMPLES_PER_SYM, 16, samples played per symbol; must be ≤ 2^IDX_W and ≥ 2

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  playback enable; low freezes sequencing
- sym_in  in  SYM_W  incoming symbol
- sym_valid  in  1  sym_in valid
- sym_ready  out  1  buffer can accept a symbol
- tbl_sel  out  SYM_W  table select to the waveform bank
- sample_idx  out  IDX_W  entry index to the waveform bank
- sample_valid  out  1  tbl_sel/sample_idx address a live sample this cycle
- sym_start  out  1  pulse on sample_idx==0 of each played symbol
- underrun  out  1  one-cycle pulse when a symbol ends with no successor buffered
- busy  out  1  state != IDLE

Behaviour:
- Reset values: tbl_sel=0, sample_idx=0, sample_valid=0, sym_start=0, underrun=0, busy=0, buffer empty, sym_ready=1, state=IDLE.
- Reset mid-symbol aborts immediately: no underrun pulse, and the buffered symbol is discarded.
- Buffer handshake:
  - One-entry holding register.
  - sym_ready = !buf_full; it is combinational from the registered flag only, never from sym_valid.
  - A symbol is accepted when sym_valid && sym_ready.
  - Simultaneous accept and consume in the same cycle is impossible by construction (accept requires empty). The buffer frees on consume and accepts again on the next cycle.
- State machine: IDLE, PLAY.
  - IDLE: sample_valid=0, outputs hold their last values.
  - IDLE -> PLAY:
    - Condition: buf_full && en.
    - Next cycle: tbl_sel=buffered symbol, sample_idx=0, sample_valid=1, sym_start=1, buffer cleared.
    - Latency: a symbol accepted at edge N with an idle sequencer gives its first sample at edge N+1.
  - PLAY with en=1:
    - sample_idx increments every clock.
    - At sample_idx==SAMPLES_PER_SYM-1 with buf_full, load the next symbol: sample_idx=0, sym_start=1, buffer cleared. There is no gap cycle.
    - At sample_idx==SAMPLES_PER_SYM-1 with the buffer empty: go to IDLE, sample_valid=0, underrun=1 for one cycle.
  - PLAY with en=0: state, tbl_sel and sample_idx hold; sample_valid=0; sym_start=0. Buffer acceptance is still allowed.
  - en deasserted on the last sample: hold the last sample; the end-of-symbol decision happens on the first enabled cycle.
- Index arithmetic:
  - Compare against SAMPLES_PER_SYM-1 explicitly; never rely on natural IDX_W wrap.
  - Non-power-of-two SAMPLES_PER_SYM (e.g. 12) must wrap at 11.
- busy=1 in PLAY including frozen cycles.

Optional Feature:
- Macro: QSEQ_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt (16 bit), which counts underrun pulses.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
  - Adds input cnt_clr (1 bit), which clears the counter synchronously. If clear and underrun coincide, the result is 0.
- When undefined: the port, counter and clear input are absent; all other behaviour is identical.

Decomposition:
- Shared package qam_pkg: SYM_W/IDX_W defaults, SAMPLES_PER_SYM default, and the state enum (IDLE=1'b0, PLAY=1'b1).
- One sub-module, qseq_hold_buf: the single-entry valid/ready holding register with ports load, consume, data, full.
- The sequencer FSM and index counter stay in the top module.

Test Plan:
- Reset then single symbol: sym_in=4'd11 accepted at edge 5 -> edges 6..21 show tbl_sel=11, sample_idx 0..15, sample_valid=1, sym_start only at edge 6; underrun pulse at edge 22; busy low from edge 22.
- Back-to-back: symbols 3 then 12 presented continuously -> 32 consecutive valid cycles, idx wraps 15->0 with tbl_sel 3->12 on the same edge, no underrun; sym_ready deasserts while the buffer is full.
- Enable freeze: en=0 for 4 cycles at sample_idx=7 -> idx stays 7, sample_valid=0 for those 4 cycles, resumes at 8; the total symbol still contains 16 valid samples.
- Reset mid-operation: rst at sample_idx=9 with symbol 5 buffered -> next cycle all outputs at reset values, sym_ready=1, no underrun; the buffered symbol is never played.
- SAMPLES_PER_SYM=12 build: symbol 2 -> idx runs 0..11, then underrun; idx never reaches 12.
- QSEQ_UNDERRUN_CNT_EN build: 3 isolated symbols -> underrun_cnt=3; cnt_clr asserted in the same cycle as an underrun -> underrun_cnt=0.
